// File: rtl/y86_decode_stage.sv
// Y86-64 decode / register-read stage: decodes the F->D word, reads and forwards operands, registers the D->E word.
// Optional macro RSP_INIT_EN: when defined, reset loads %rsp (r4) with STACK_TOP instead of zero.
module y86_decode_stage #(
  parameter logic [63:0] STACK_TOP = 64'h0000_0000_0000_0200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [144:0] decode_reg,
  input  logic         E_bubble,
  input  logic [3:0]   e_dstE,
  input  logic [63:0]  e_valE,
  input  logic [3:0]   M_dstE,
  input  logic [63:0]  M_valE,
  input  logic [3:0]   M_dstM,
  input  logic [63:0]  m_valM,
  input  logic [3:0]   W_dstE,
  input  logic [63:0]  W_valE,
  input  logic [3:0]   W_dstM,
  input  logic [63:0]  W_valM,
  output logic [216:0] execute_reg
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  localparam logic [216:0] BUBBLE = {4'h1, 4'h0, 64'd0, 64'd0, 64'd0,
                                     RNONE, RNONE, RNONE, RNONE, 1'b0};

  logic        w_err;
  logic [3:0]  w_icode, w_ifun, w_ra, w_rb;
  logic [63:0] w_valc, w_valp;

  assign w_err   = decode_reg[144];
  assign w_icode = decode_reg[143:140];
  assign w_ifun  = decode_reg[139:136];
  assign w_ra    = decode_reg[135:132];
  assign w_rb    = decode_reg[131:128];
  assign w_valc  = decode_reg[127:64];
  assign w_valp  = decode_reg[63:0];

  logic [3:0]  w_src_a, w_src_b, w_dst_e, w_dst_m;
  logic [63:0] w_rf_a, w_rf_b, w_val_a, w_val_b;
  logic [63:0] r_regs [0:14];
  logic [216:0] r_execute_reg;

  // NOTE: every always_comb output gets a default before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    w_src_a = RNONE;
    w_src_b = RNONE;
    w_dst_e = RNONE;
    w_dst_m = RNONE;
    case (w_icode)
      4'h2, 4'h4, 4'h6, 4'hA: w_src_a = w_ra;
      4'h9, 4'hB:             w_src_a = RRSP;
      default:                w_src_a = RNONE;
    endcase
    case (w_icode)
      4'h4, 4'h5, 4'h6:       w_src_b = w_rb;
      4'h8, 4'h9, 4'hA, 4'hB: w_src_b = RRSP;
      default:                w_src_b = RNONE;
    endcase
    case (w_icode)
      4'h2, 4'h3, 4'h6:       w_dst_e = w_rb;
      4'h8, 4'h9, 4'hA, 4'hB: w_dst_e = RRSP;
      default:                w_dst_e = RNONE;
    endcase
    case (w_icode)
      4'h5, 4'hB: w_dst_m = w_ra;
      default:    w_dst_m = RNONE;
    endcase
  end

  // RNONE has no storage behind it and always reads as zero.
  assign w_rf_a = (w_src_a == RNONE) ? 64'd0 : r_regs[w_src_a];
  assign w_rf_b = (w_src_b == RNONE) ? 64'd0 : r_regs[w_src_b];

  // Forwarding: youngest producer wins; RNONE sources never forward.
  always_comb begin
    w_val_a = w_rf_a;
    if (w_icode == 4'h7 || w_icode == 4'h8) w_val_a = w_valp;
    else if (w_src_a == RNONE)              w_val_a = 64'd0;
    else if (w_src_a == e_dstE)             w_val_a = e_valE;
    else if (w_src_a == M_dstM)             w_val_a = m_valM;
    else if (w_src_a == M_dstE)             w_val_a = M_valE;
    else if (w_src_a == W_dstM)             w_val_a = W_valM;
    else if (w_src_a == W_dstE)             w_val_a = W_valE;
  end

  always_comb begin
    w_val_b = w_rf_b;
    if (w_src_b == RNONE)       w_val_b = 64'd0;
    else if (w_src_b == e_dstE) w_val_b = e_valE;
    else if (w_src_b == M_dstM) w_val_b = m_valM;
    else if (w_src_b == M_dstE) w_val_b = M_valE;
    else if (w_src_b == W_dstM) w_val_b = W_valM;
    else if (w_src_b == W_dstE) w_val_b = W_valE;
  end

  // NOTE: the register file is architectural state that must start clean, so it is reset explicitly.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
`ifdef RSP_INIT_EN
        r_regs[i] <= (i == 4) ? STACK_TOP : 64'd0;
`else
        r_regs[i] <= 64'd0;
`endif
      end
    end else begin
      // The M port is written last so it wins when both ports target one register.
      if (W_dstE != RNONE) r_regs[W_dstE] <= W_valE;
      if (W_dstM != RNONE) r_regs[W_dstM] <= W_valM;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || E_bubble) begin
      r_execute_reg <= BUBBLE;
    end else begin
      r_execute_reg <= {w_icode, w_ifun, w_valc, w_val_a, w_val_b,
                        w_dst_e, w_dst_m, w_src_a, w_src_b, w_err};
    end
  end

  assign execute_reg = r_execute_reg;

endmodule

// File: tb/tb_y86_decode_stage.sv
// Directed self-checking bench for y86_decode_stage: decode, forwarding priority, register file, bubble and reset.
module tb_y86_decode_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [144:0] decode_reg;
  logic         E_bubble;
  logic [3:0]   e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0]  e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [216:0] execute_reg;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [3:0] F = 4'hF;
`ifdef RSP_INIT_EN
  localparam logic [63:0] RSP_RST = 64'h200;
`else
  localparam logic [63:0] RSP_RST = 64'h0;
`endif

  y86_decode_stage dut (
    .clk(clk), .rst(rst), .decode_reg(decode_reg), .E_bubble(E_bubble),
    .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_valE(M_valE),
    .M_dstM(M_dstM), .m_valM(m_valM), .W_dstE(W_dstE), .W_valE(W_valE),
    .W_dstM(W_dstM), .W_valM(W_valM), .execute_reg(execute_reg)
  );

  always #5 clk = ~clk;

  function automatic logic [144:0] mk_d(input logic err, input logic [3:0] icode, input logic [3:0] ifun,
                                        input logic [3:0] ra, input logic [3:0] rb,
                                        input logic [63:0] valc, input logic [63:0] valp);
    return {err, icode, ifun, ra, rb, valc, valp};
  endfunction

  function automatic logic [216:0] mk_e(input logic [3:0] icode, input logic [3:0] ifun, input logic [63:0] valc,
                                        input logic [63:0] vala, input logic [63:0] valb,
                                        input logic [3:0] dste, input logic [3:0] dstm,
                                        input logic [3:0] srca, input logic [3:0] srcb, input logic err);
    return {icode, ifun, valc, vala, valb, dste, dstm, srca, srcb, err};
  endfunction

  task automatic check(input string tag, input logic [216:0] act, input logic [216:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic idle_fwd();
    e_dstE = F; e_valE = '0; M_dstE = F; M_valE = '0; M_dstM = F; m_valM = '0;
    W_dstE = F; W_valE = '0; W_dstM = F; W_valM = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [216:0] bubble;

  initial begin
    bubble = mk_e(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, F, F, F, F, 1'b0);
    idle_fwd();
    E_bubble = 1'b0;

    // Reset beats a pending register-file write.
    rst = 1'b1;
    decode_reg = mk_d(1'b0, 4'h6, 4'h0, 4'h1, 4'h2, 64'd0, 64'd0);
    W_dstE = 4'h3; W_valE = 64'h99;
    step();
    check("reset_bubble", execute_reg, bubble);

    rst = 1'b0; idle_fwd();
    decode_reg = mk_d(1'b0, 4'h2, 4'h0, 4'h3, 4'h4, 64'd0, 64'd0);
    step();
    check("reset_r3_zero", execute_reg, mk_e(4'h2, 4'h0, 64'd0, 64'd0, 64'd0, 4'h4, F, 4'h3, F, 1'b0));

    decode_reg = mk_d(1'b0, 4'h2, 4'h0, 4'h4, 4'h1, 64'd0, 64'd0);
    step();
    check("reset_rsp", execute_reg, mk_e(4'h2, 4'h0, 64'd0, RSP_RST, 64'd0, 4'h1, F, 4'h4, F, 1'b0));

    // Writeback then read through the register file.
    decode_reg = mk_d(1'b0, 4'h1, 4'h0, F, F, 64'd0, 64'd0);
    W_dstE = 4'h3; W_valE = 64'h1234;
    step();
    check("nop", execute_reg, bubble);
    idle_fwd();
    decode_reg = mk_d(1'b0, 4'h6, 4'h0, 4'h3, 4'h3, 64'd0, 64'd0);
    step();
    check("wb_then_read", execute_reg, mk_e(4'h6, 4'h0, 64'd0, 64'h1234, 64'h1234, 4'h3, F, 4'h3, 4'h3, 1'b0));

    // Forwarding priority on srcA = r2.
    decode_reg = mk_d(1'b0, 4'h6, 4'h1, 4'h2, 4'h7, 64'd0, 64'd0);
    e_dstE = 4'h2; e_valE = 64'hAA; M_dstM = 4'h2; m_valM = 64'hBB; W_dstE = 4'h2; W_valE = 64'hCC;
    step();
    check("fwd_e", execute_reg, mk_e(4'h6, 4'h1, 64'd0, 64'hAA, 64'd0, 4'h7, F, 4'h2, 4'h7, 1'b0));
    e_dstE = F;
    step();
    check("fwd_m_valM", execute_reg, mk_e(4'h6, 4'h1, 64'd0, 64'hBB, 64'd0, 4'h7, F, 4'h2, 4'h7, 1'b0));
    M_dstM = F; M_dstE = 4'h2; M_valE = 64'hDD; W_dstM = 4'h2; W_valM = 64'hEE;
    step();
    check("fwd_M_valE", execute_reg, mk_e(4'h6, 4'h1, 64'd0, 64'hDD, 64'd0, 4'h7, F, 4'h2, 4'h7, 1'b0));
    M_dstE = F;
    step();
    check("fwd_W_valM", execute_reg, mk_e(4'h6, 4'h1, 64'd0, 64'hEE, 64'd0, 4'h7, F, 4'h2, 4'h7, 1'b0));
    idle_fwd();
    step();
    check("rf_dual_write_m_wins", execute_reg, mk_e(4'h6, 4'h1, 64'd0, 64'hEE, 64'd0, 4'h7, F, 4'h2, 4'h7, 1'b0));

    // CALL and JXX take valA from valP.
    decode_reg = mk_d(1'b0, 4'h8, 4'h0, F, F, 64'h1000, 64'h40);
    e_dstE = 4'h4; e_valE = 64'h77;
    step();
    check("call", execute_reg, mk_e(4'h8, 4'h0, 64'h1000, 64'h40, 64'h77, 4'h4, F, F, 4'h4, 1'b0));
    idle_fwd();
    decode_reg = mk_d(1'b0, 4'h7, 4'h3, F, F, 64'h300, 64'h88);
    step();
    check("jxx", execute_reg, mk_e(4'h7, 4'h3, 64'h300, 64'h88, 64'd0, F, F, F, F, 1'b0));

    // POP with a same-cycle dual write to r4.
    decode_reg = mk_d(1'b0, 4'hB, 4'h0, 4'h5, F, 64'd0, 64'd0);
    W_dstE = 4'h4; W_valE = 64'h1; W_dstM = 4'h4; W_valM = 64'h2;
    step();
    check("popq", execute_reg, mk_e(4'hB, 4'h0, 64'd0, 64'h2, 64'h2, 4'h4, 4'h5, 4'h4, 4'h4, 1'b0));
    idle_fwd();
    decode_reg = mk_d(1'b0, 4'h2, 4'h0, 4'h4, 4'h0, 64'd0, 64'd0);
    step();
    check("r4_after_pop_write", execute_reg, mk_e(4'h2, 4'h0, 64'd0, 64'h2, 64'd0, 4'h0, F, 4'h4, F, 1'b0));

    // Bubble over IRMOV; the register file still takes the write.
    decode_reg = mk_d(1'b0, 4'h3, 4'h0, F, 4'h6, 64'hDEAD, 64'h10);
    E_bubble = 1'b1; W_dstE = 4'h9; W_valE = 64'h55;
    step();
    check("e_bubble", execute_reg, bubble);
    E_bubble = 1'b0; idle_fwd();
    step();
    check("irmov", execute_reg, mk_e(4'h3, 4'h0, 64'hDEAD, 64'd0, 64'd0, 4'h6, F, F, F, 1'b0));
    decode_reg = mk_d(1'b0, 4'h2, 4'h0, 4'h9, 4'h1, 64'd0, 64'd0);
    step();
    check("write_during_bubble", execute_reg, mk_e(4'h2, 4'h0, 64'd0, 64'h55, 64'd0, 4'h1, F, 4'h9, F, 1'b0));

    // HALT / err pass through; undefined icode decodes to RNONE and F never forwards.
    decode_reg = mk_d(1'b1, 4'h0, 4'h0, 4'h1, 4'h2, 64'd0, 64'd0);
    step();
    check("halt_err", execute_reg, mk_e(4'h0, 4'h0, 64'd0, 64'd0, 64'd0, F, F, F, F, 1'b1));
    decode_reg = mk_d(1'b1, 4'hC, 4'h0, 4'h1, 4'h2, 64'h5, 64'h9);
    e_dstE = F; e_valE = 64'h123; W_dstM = F; W_valM = 64'h456;
    step();
    check("undef_icode", execute_reg, mk_e(4'hC, 4'h0, 64'h5, 64'd0, 64'd0, F, F, F, F, 1'b1));
    idle_fwd();

    // Reset again: clears registers and overrides writes.
    rst = 1'b1;
    W_dstE = 4'h5; W_valE = 64'h66; W_dstM = 4'h2; W_valM = 64'h77;
    step();
    check("reset2_bubble", execute_reg, bubble);
    rst = 1'b0; idle_fwd();
    decode_reg = mk_d(1'b0, 4'h2, 4'h0, 4'h5, 4'h0, 64'd0, 64'd0);
    step();
    check("reset2_r5", execute_reg, mk_e(4'h2, 4'h0, 64'd0, 64'd0, 64'd0, 4'h0, F, 4'h5, F, 1'b0));
    decode_reg = mk_d(1'b0, 4'h2, 4'h0, 4'h2, 4'h0, 64'd0, 64'd0);
    step();
    check("reset2_r2", execute_reg, mk_e(4'h2, 4'h0, 64'd0, 64'd0, 64'd0, 4'h0, F, 4'h2, F, 1'b0));
    decode_reg = mk_d(1'b0, 4'h2, 4'h0, 4'h4, 4'h0, 64'd0, 64'd0);
    step();
    check("reset2_rsp", execute_reg, mk_e(4'h2, 4'h0, 64'd0, RSP_RST, 64'd0, 4'h0, F, 4'h4, F, 1'b0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
